// File: rtl/wb_regfile_if.sv
// Writeback/decode bus of the register file: W-stage write inputs, decode read
// ports, and the program status returned to the pipeline.
interface wb_regfile_if;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic        W_stall;
    logic [2:0]  Stat;
    logic        halted;
    logic [63:0] retired;

    modport master (
        output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
        input  d_rvalA, d_rvalB, W_stall, Stat, halted, retired
    );

    modport slave (
        input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
        output d_rvalA, d_rvalB, W_stall, Stat, halted, retired
    );
endinterface

// File: rtl/wb_regfile.sv
// 15x64 register file with writeback-stage commit, same-cycle write-through
// bypass to two decode read ports, sticky exception status and retire counter.
module wb_regfile (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] ICODE_NOP = 4'h1;

    logic [63:0] regs_r [0:14];
    logic [2:0]  stat_r;
    logic        halted_r;
    logic [63:0] retired_r;

    logic        exc_s;
    logic        commit_s;
    logic        wr_e_s;
    logic        wr_m_s;
    logic [2:0]  exc_stat_s;

    // Commit qualification; reset suppresses the write so the bypass never
    // shows a value that will not land in the array.
    always_comb begin
        exc_s      = (bus.W_stat >= STAT_HLT);
        commit_s   = (bus.W_stat == STAT_AOK) && !halted_r && !rst;
        wr_m_s     = commit_s && (bus.W_dstM != RNONE);
        wr_e_s     = commit_s && (bus.W_dstE != RNONE) && (bus.W_dstE != bus.W_dstM);
        if (bus.W_stat > STAT_INS) begin
            exc_stat_s = STAT_INS;
        end else begin
            exc_stat_s = bus.W_stat;
        end
    end

    function automatic logic [63:0] read_port(input logic [3:0] src);
        logic [63:0] val;
        if (src == RNONE) begin
            val = 64'h0;
        end else if (wr_m_s && (bus.W_dstM == src)) begin
            val = bus.W_valM;
        end else if (wr_e_s && (bus.W_dstE == src)) begin
            val = bus.W_valE;
        end else begin
            val = regs_r[src];
        end
        return val;
    endfunction

    // Decode read ports with write-through bypass, and the stall request.
    always_comb begin
        bus.d_rvalA = read_port(bus.d_srcA);
        bus.d_rvalB = read_port(bus.d_srcB);
        bus.W_stall = exc_s || halted_r;
    end

    // Register array, status latch and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= 64'h0;
            end
            stat_r    <= STAT_AOK;
            halted_r  <= 1'b0;
            retired_r <= 64'h0;
        end else begin
            if (wr_m_s) begin
                regs_r[bus.W_dstM] <= bus.W_valM;
            end
            if (wr_e_s) begin
                regs_r[bus.W_dstE] <= bus.W_valE;
            end
            if (!halted_r && exc_s) begin
                stat_r   <= exc_stat_s;
                halted_r <= 1'b1;
            end
            if (commit_s && (bus.W_icode != ICODE_NOP)) begin
                retired_r <= retired_r + 64'd1;
            end
        end
    end

    assign bus.Stat    = stat_r;
    assign bus.halted  = halted_r;
    assign bus.retired = retired_r;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations are queued when stimulus is
// applied and popped/compared once the DUT output is due.
module tb_wb_regfile;
    localparam int K_RVALA = 0;
    localparam int K_RVALB = 1;
    localparam int K_STAT  = 2;
    localparam int K_HALT  = 3;
    localparam int K_RET   = 4;
    localparam int K_STALL = 5;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic logic [63:0] obs(input int kind);
        case (kind)
            K_RVALA: return bus.d_rvalA;
            K_RVALB: return bus.d_rvalB;
            K_STAT:  return {61'h0, bus.Stat};
            K_HALT:  return {63'h0, bus.halted};
            K_RET:   return bus.retired;
            K_STALL: return {63'h0, bus.W_stall};
            default: return 64'hDEAD;
        endcase
    endfunction

    task automatic push(input int kind, input logic [63:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [63:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.kind);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input logic [2:0] st, input logic [3:0] ic,
                           input logic [3:0] de, input logic [63:0] ve,
                           input logic [3:0] dm, input logic [63:0] vm);
        bus.W_stat  = st;
        bus.W_icode = ic;
        bus.W_dstE  = de;
        bus.W_valE  = ve;
        bus.W_dstM  = dm;
        bus.W_valM  = vm;
    endtask

    task automatic bubble();
        drive_w(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    endtask

    task automatic read_reg(input logic [3:0] idx, input logic [63:0] exp, input string tag);
        bus.d_srcA = idx;
        #1;
        push(K_RVALA, exp, tag);
        drain();
    endtask

    task automatic status(input logic [2:0] st, input logic h, input logic [63:0] ret,
                          input string tag);
        push(K_STAT, {61'h0, st}, {tag, "_stat"});
        push(K_HALT, {63'h0, h}, {tag, "_halted"});
        push(K_RET, ret, {tag, "_retired"});
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bubble();
        bus.d_srcA = 4'hF;
        bus.d_srcB = 4'hF;
        tick();
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 15; i++) begin
            read_reg(i[3:0], 64'h0, $sformatf("reset_r%0d", i));
        end
        bus.d_srcB = 4'hF;
        #1;
        push(K_RVALB, 64'h0, "rnone_b");
        push(K_STALL, 64'h0, "reset_stall");
        drain();
        status(3'd1, 1'b0, 64'd0, "reset");

        // Single E write with bypass
        drive_w(3'd1, 4'h6, 4'd3, 64'h55, 4'hF, 64'h0);
        bus.d_srcA = 4'd3;
        #1;
        push(K_RVALA, 64'h55, "bypass_e");
        push(K_STALL, 64'h0, "aok_stall");
        drain();
        tick();
        bubble();
        read_reg(4'd3, 64'h55, "r3_write");
        status(3'd1, 1'b0, 64'd1, "after_w1");

        // Same destination: M-port wins
        drive_w(3'd1, 4'h5, 4'd4, 64'h10, 4'd4, 64'h20);
        bus.d_srcA = 4'd4;
        #1;
        push(K_RVALA, 64'h20, "bypass_m_prio");
        drain();
        tick();
        bubble();
        read_reg(4'd4, 64'h20, "r4_m_prio");
        status(3'd1, 1'b0, 64'd2, "after_w2");

        // Dual write to distinct registers, including R14 boundary
        drive_w(3'd1, 4'h5, 4'd6, 64'hA, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.d_srcA = 4'd6;
        bus.d_srcB = 4'd14;
        #1;
        push(K_RVALA, 64'hA, "bypass_dual_e");
        push(K_RVALB, 64'hFFFF_FFFF_FFFF_FFFF, "bypass_dual_m");
        drain();
        tick();
        bubble();
        bus.d_srcB = 4'hF;
        read_reg(4'd6, 64'hA, "r6_dual");
        read_reg(4'd14, 64'hFFFF_FFFF_FFFF_FFFF, "r14_dual");
        status(3'd1, 1'b0, 64'd3, "after_w3");

        // Bubbles and nops: no writes, no retire
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                drive_w(3'd0, 4'h6, 4'd8, 64'h123, 4'd9, 64'h456);
            end else begin
                drive_w(3'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
            end
            tick();
        end
        bubble();
        read_reg(4'd8, 64'h0, "r8_bubble");
        read_reg(4'd9, 64'h0, "r9_bubble");
        status(3'd1, 1'b0, 64'd3, "after_bubbles");

        // Exception: ADR halts and blocks its own write
        drive_w(3'd1, 4'h6, 4'd2, 64'h11, 4'hF, 64'h0);
        tick();
        drive_w(3'd3, 4'h6, 4'd2, 64'h99, 4'hF, 64'h0);
        bus.d_srcA = 4'd2;
        #1;
        push(K_RVALA, 64'h11, "adr_no_bypass");
        push(K_STALL, 64'h1, "adr_stall");
        push(K_STAT, 64'd1, "adr_stat_pre");
        drain();
        tick();
        bubble();
        #1;
        push(K_STALL, 64'h1, "halted_stall");
        drain();
        status(3'd3, 1'b1, 64'd4, "halted");
        drive_w(3'd1, 4'h6, 4'd2, 64'h77, 4'hF, 64'h0);
        tick();
        drive_w(3'd7, 4'h6, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        bubble();
        read_reg(4'd2, 64'h11, "r2_frozen");
        status(3'd3, 1'b1, 64'd4, "frozen");

        // Reset beats a same-cycle write and clears the halt
        rst = 1'b1;
        drive_w(3'd1, 4'h6, 4'd5, 64'h7, 4'hF, 64'h0);
        tick();
        rst = 1'b0;
        bubble();
        read_reg(4'd5, 64'h0, "r5_rst_prio");
        read_reg(4'd2, 64'h0, "r2_rst_clear");
        status(3'd1, 1'b0, 64'd0, "rst_prio");

        // Out-of-range status loads as INS
        drive_w(3'd6, 4'h6, 4'hF, 64'h0, 4'hF, 64'h0);
        #1;
        push(K_STALL, 64'h1, "st6_stall");
        drain();
        tick();
        bubble();
        status(3'd4, 1'b1, 64'd0, "st6_ins");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have ports: W_stat  in  3  writeback-stage status: 0=BUB, 1=AOK, 2=HLT, 3=ADR, 4=INS; 5-7 treated as INS.
REQ-004 SHALL have ports: W_icode  in  4  writeback-stage instruction code; 4'h1 = nop.
REQ-005 SHALL have ports: W_valE  in  64  ALU result to write to W_dstE.
REQ-006 SHALL have ports: W_valM  in  64  memory result to write to W_dstM.
REQ-007 SHALL have ports: W_dstE  in  4  destination of valE; 4'hF = RNONE, no write.
REQ-008 SHALL have ports: W_dstM  in  4  destination of valM; 4'hF = RNONE, no write.
REQ-009 SHALL have ports: d_srcA  in  4  decode read port A index; 4'hF = none.
REQ-010 SHALL have ports: d_srcB  in  4  decode read port B index; 4'hF = none.
REQ-011 SHALL have ports: d_rvalA  out  64  register value for d_srcA.
REQ-012 SHALL have ports: d_rvalB  out  64  register value for d_srcB.
REQ-013 SHALL have ports: W_stall  out  1  stall request to the W pipeline register.
REQ-014 SHALL have ports: Stat  out  3  registered program status.
REQ-015 SHALL have ports: halted  out  1  registered; processor has stopped retiring.
REQ-016 SHALL have ports: retired  out  64  registered count of retired instructions.

Function
REQ-017 SHALL hold 15 registers of 64 bits, indices 0-14; index 15 not storage.
REQ-018 SHALL commit a write only when W_stat==AOK and halted==0; BUB, HLT, ADR, INS and halted inhibit both write ports.
REQ-019 SHALL write W_valE to R[W_dstE] and W_valM to R[W_dstM] on the same posedge when both are enabled and the indices differ.
REQ-020 SHALL write W_valM only when W_dstE==W_dstM!=4'hF; M-port has priority.
REQ-021 SHALL drive d_rvalA/d_rvalB combinationally from the array, with write-through bypass of the same-cycle committing write: M-port match first, then E-port match, else array.
REQ-022 SHALL drive d_rvalA/d_rvalB as 64'h0 when the source index is 4'hF.
REQ-023 SHALL drive W_stall combinationally high when W_stat is in {HLT, ADR, INS, 5-7} or halted==1; low otherwise.
REQ-024 SHALL, on the first posedge with halted==0 and an exceptional W_stat, load Stat<=W_stat (5-7 load as 4) and set halted<=1.
REQ-025 SHALL keep Stat and halted frozen while halted==1 until reset; later W_stat values are ignored.
REQ-026 SHALL keep Stat==AOK while W_stat is BUB or AOK and halted==0.
REQ-027 SHALL increment retired by 1, mod 2^64, on each posedge with W_stat==AOK, W_icode!=4'h1 and halted==0.
REQ-028 SHALL apply all register updates exactly one cycle after the W inputs are sampled; no other internal latency.

Reset
REQ-029 SHALL on posedge with rst==1 clear R0-R14 to 64'h0, Stat to AOK (3'd1), halted to 0 and retired to 0.
REQ-030 SHALL give rst priority over any same-cycle write, status latch or count increment.
REQ-031 SHALL keep W_stall purely combinational; it follows W_stat during and after reset.

Verification
REQ-032 Scenario: rst 1 cycle -> every R reads 0, Stat=1, halted=0, retired=0, W_stall=0.
REQ-033 Scenario: W_stat=1, icode=6, dstE=3, valE=0x55, dstM=F -> next cycle R3=0x55, retired=1; the same cycle, d_srcA=3 gives 0x55 through bypass.
REQ-034 Scenario: W_stat=1, dstE=dstM=4, valE=0x10, valM=0x20 -> R4=0x20 only.
REQ-035 Scenario: W_stat=3, dstE=2, valE=0x99 -> R2 unchanged, W_stall=1, then Stat=3, halted=1; later W_stat=1 writes are ignored, Stat stays 3.
REQ-036 Scenario: W_stat=0 or icode=1 bubbles x5 -> no writes, retired unchanged, Stat=1.
REQ-037 Scenario: rst=1 in the same cycle as W_stat=1, dstE=5, valE=0x7 -> R5=0, retired=0.
